// File: rtl/pipelined_decode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_decode_ctrl_if
// Description : Bus bundle between the IF/ID stage and the registered decode
//               controller. It carries the instruction fields, the pipeline
//               hold/flush controls, the registered ID/EX control bundle and
//               the MDU status lines.
//   master : IF/ID side. Drives instr_valid, OP, FN, stall_in and flush.
//            Receives the decoded controls, mdu_busy and mdu_stall.
//   slave  : decode controller. This is the mirror image of master.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_decode_ctrl_if;
  logic       instr_valid;
  logic [5:0] OP;
  logic [5:0] FN;
  logic       stall_in;
  logic       flush;

  logic       Regwrite;
  logic       Memwrite;
  logic       Branch;
  logic       Jump;
  logic       ALUSrc;
  logic [1:0] RegDst;
  logic [1:0] ImmOp;
  logic [2:0] WBSrc;
  logic [2:0] AluControl;
  logic       brOp;
  logic       MultStart;
  logic       MultSgn;
  logic       DivStart;
  logic       DivSgn;
  logic       illegal;
  logic       mdu_busy;
  logic       mdu_stall;

  modport master (
    output instr_valid, OP, FN, stall_in, flush,
    input  Regwrite, Memwrite, Branch, Jump, ALUSrc, RegDst, ImmOp, WBSrc,
           AluControl, brOp, MultStart, MultSgn, DivStart, DivSgn, illegal,
           mdu_busy, mdu_stall
  );

  modport slave (
    input  instr_valid, OP, FN, stall_in, flush,
    output Regwrite, Memwrite, Branch, Jump, ALUSrc, RegDst, ImmOp, WBSrc,
           AluControl, brOp, MultStart, MultSgn, DivStart, DivSgn, illegal,
           mdu_busy, mdu_stall
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_decode_ctrl
// Description : Registered MIPS instruction decoder that feeds the ID/EX
//               register. It also contains a multiply/divide issue tracker.
//               While the MDU is busy, the tracker stalls decode of any
//               instruction that depends on the MDU (mult/div/mflo/mfhi).
// Ports       : clk    - rising-edge clock
//               reset  - synchronous active-high reset
//               bus    - pipelined_decode_ctrl_if.slave. It carries the
//                        instruction and hold/flush inputs, the registered
//                        control bundle, mdu_busy (FSM not idle) and
//                        mdu_stall (combinational IF/ID freeze).
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_decode_ctrl #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32,
  parameter int unsigned HAS_DIV  = 1,
  parameter int unsigned CNT_W    = 6
) (
  input wire clk,
  input wire reset,
  pipelined_decode_ctrl_if.slave bus
);

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic [1:0] regdst;
    logic [1:0] immop;
    logic [2:0] wbsrc;
    logic [2:0] aluctl;
    logic       brop;
    logic       mult_start;
    logic       mult_sgn;
    logic       div_start;
    logic       div_sgn;
    logic       illegal;
  } ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam ctrl_t             c_bubble    = '0;
  localparam logic [CNT_W-1:0]  c_mult_init = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0]  c_div_init  = CNT_W'(DIV_LAT - 1);

  ctrl_t            ctrl_q, ctrl_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t w_dec;
  logic  w_legal;
  logic  w_mdu_dep;
  logic  w_mdu_busy;
  logic  w_mdu_stall;
  logic  w_accept;

  // --------------------------------------------------------------------------
  // Combinational decode of OP/FN. Any unrecognised encoding collapses to a
  // bubble with only the illegal flag set, so the outputs are never X.
  // --------------------------------------------------------------------------
  always_comb begin
    w_dec     = c_bubble;
    w_legal   = 1'b1;
    w_mdu_dep = 1'b0;
    case (bus.OP)
      6'b000000: begin
        w_dec.regwrite = 1'b1;
        w_dec.regdst   = 2'b01;
        case (bus.FN)
          6'b100000: w_dec.aluctl = 3'b010;  // add
          6'b100101: w_dec.aluctl = 3'b001;  // or
          6'b100100: w_dec.aluctl = 3'b000;  // and
          6'b100010: w_dec.aluctl = 3'b110;  // sub
          6'b101010: w_dec.aluctl = 3'b111;  // slt
          6'b100110: w_dec.aluctl = 3'b100;  // xor
          6'b000101: w_dec.aluctl = 3'b101;  // xnor
          6'b011000: begin                   // mult
            w_dec.mult_start = 1'b1;
            w_dec.mult_sgn   = 1'b1;
            w_mdu_dep        = 1'b1;
          end
          6'b011001: begin                   // multu
            w_dec.mult_start = 1'b1;
            w_mdu_dep        = 1'b1;
          end
          6'b011010: begin                   // div
            if (HAS_DIV != 0) begin
              w_dec.div_start = 1'b1;
              w_dec.div_sgn   = 1'b1;
              w_mdu_dep       = 1'b1;
            end else begin
              w_legal = 1'b0;
            end
          end
          6'b011011: begin                   // divu
            if (HAS_DIV != 0) begin
              w_dec.div_start = 1'b1;
              w_mdu_dep       = 1'b1;
            end else begin
              w_legal = 1'b0;
            end
          end
          6'b010010: begin                   // mflo
            w_dec.wbsrc = 3'b100;
            w_mdu_dep   = 1'b1;
          end
          6'b010000: begin                   // mfhi
            w_dec.wbsrc = 3'b011;
            w_mdu_dep   = 1'b1;
          end
          default:   w_legal = 1'b0;
        endcase
      end
      6'b100011: begin                       // lw
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.aluctl   = 3'b010;
        w_dec.wbsrc    = 3'b001;
      end
      6'b101011: begin                       // sw
        w_dec.memwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.aluctl   = 3'b010;
      end
      6'b000100, 6'b000101: begin            // beq / bne
        w_dec.branch = 1'b1;
        w_dec.aluctl = 3'b110;
        w_dec.brop   = bus.OP[0];
      end
      6'b001000: begin                       // addi
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.aluctl   = 3'b010;
      end
      6'b000010: begin                       // jal
        w_dec.regwrite = 1'b1;
        w_dec.jump     = 1'b1;
        w_dec.regdst   = 2'b10;
        w_dec.wbsrc    = 3'b010;
      end
      6'b001101, 6'b001100, 6'b001110: begin // ori / andi / xori
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.immop    = 2'b01;
        case (bus.OP[1:0])
          2'b01:   w_dec.aluctl = 3'b001;
          2'b00:   w_dec.aluctl = 3'b000;
          default: w_dec.aluctl = 3'b100;
        endcase
      end
      6'b001010: begin                       // slti
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.aluctl   = 3'b111;
      end
      6'b001111: begin                       // lui
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.immop    = 2'b10;
        w_dec.aluctl   = 3'b010;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_dec         = c_bubble;
      w_dec.illegal = 1'b1;
      w_mdu_dep     = 1'b0;
    end
  end

  assign w_mdu_busy  = (state_q != S_IDLE);
  assign w_mdu_stall = bus.instr_valid & w_mdu_busy & w_mdu_dep;
  assign w_accept    = bus.instr_valid & ~bus.flush & ~bus.stall_in & ~w_mdu_stall;

  // --------------------------------------------------------------------------
  // ID/EX bundle next value. A held bundle keeps everything except the start
  // strobes, so each MDU op launches exactly once however long the hold lasts.
  // --------------------------------------------------------------------------
  always_comb begin
    ctrl_d = ctrl_q;
    if (bus.flush) begin
      ctrl_d = c_bubble;
    end else if (bus.stall_in) begin
      ctrl_d.mult_start = 1'b0;
      ctrl_d.div_start  = 1'b0;
    end else if (w_mdu_stall || !bus.instr_valid) begin
      ctrl_d = c_bubble;
    end else begin
      ctrl_d = w_dec;
    end
  end

  // --------------------------------------------------------------------------
  // MDU tracker next state. The counter keeps running through a hold or a
  // flush, because the unit itself does not stop once it has started.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept && w_dec.mult_start) begin
          state_d = S_MULT;
          cnt_d   = c_mult_init;
        end else if (w_accept && w_dec.div_start) begin
          state_d = S_DIV;
          cnt_d   = c_div_init;
        end
      end
      S_MULT, S_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= c_bubble;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Regwrite   = ctrl_q.regwrite;
  assign bus.Memwrite   = ctrl_q.memwrite;
  assign bus.Branch     = ctrl_q.branch;
  assign bus.Jump       = ctrl_q.jump;
  assign bus.ALUSrc     = ctrl_q.alusrc;
  assign bus.RegDst     = ctrl_q.regdst;
  assign bus.ImmOp      = ctrl_q.immop;
  assign bus.WBSrc      = ctrl_q.wbsrc;
  assign bus.AluControl = ctrl_q.aluctl;
  assign bus.brOp       = ctrl_q.brop;
  assign bus.MultStart  = ctrl_q.mult_start;
  assign bus.MultSgn    = ctrl_q.mult_sgn;
  assign bus.DivStart   = ctrl_q.div_start;
  assign bus.DivSgn     = ctrl_q.div_sgn;
  assign bus.illegal    = ctrl_q.illegal;
  assign bus.mdu_busy   = w_mdu_busy;
  assign bus.mdu_stall  = w_mdu_stall;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_decode_ctrl
// Description : Self-checking bench for pipelined_decode_ctrl. dut0 uses the
//               default parameters. dut1 has HAS_DIV=0 and receives the same
//               stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_decode_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_decode_ctrl_if if0 ();
  pipelined_decode_ctrl_if if1 ();

  assign if1.instr_valid = if0.instr_valid;
  assign if1.OP          = if0.OP;
  assign if1.FN          = if0.FN;
  assign if1.stall_in    = if0.stall_in;
  assign if1.flush       = if0.flush;

  pipelined_decode_ctrl #(.MULT_LAT(4), .DIV_LAT(32), .HAS_DIV(1), .CNT_W(6)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  pipelined_decode_ctrl #(.MULT_LAT(4), .DIV_LAT(32), .HAS_DIV(0), .CNT_W(6)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        flush;
    logic [20:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  // {Regwrite,Memwrite,Branch,Jump,ALUSrc,RegDst,ImmOp, WBSrc, AluControl,
  //  brOp, MultStart,MultSgn,DivStart,DivSgn, illegal}
  function automatic logic [20:0] mk(input logic [8:0] b, input logic [2:0] wb,
                                     input logic [2:0] alu, input logic br,
                                     input logic [3:0] mdu, input logic ill);
    return {b, wb, alu, br, mdu, ill};
  endfunction

  function automatic logic [20:0] act0();
    return {if0.Regwrite, if0.Memwrite, if0.Branch, if0.Jump, if0.ALUSrc,
            if0.RegDst, if0.ImmOp, if0.WBSrc, if0.AluControl, if0.brOp,
            if0.MultStart, if0.MultSgn, if0.DivStart, if0.DivSgn, if0.illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic st, input logic fl);
    if0.instr_valid = v;
    if0.OP          = op;
    if0.FN          = fn;
    if0.stall_in    = st;
    if0.flush       = fl;
  endtask

  task automatic add_vec(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic fl, input logic [20:0] exp, input string name);
    vec_t t;
    t.valid = v;
    t.op    = op;
    t.fn    = fn;
    t.flush = fl;
    t.exp   = exp;
    t.name  = name;
    tbl.push_back(t);
  endtask

  localparam logic [8:0] c_rtype = 9'b100000100;

  initial begin
    int busy_cnt;
    int stall_cnt;
    int ms_cnt;

    add_vec(1, 6'b000000, 6'b100000, 0, mk(c_rtype,      3'b000, 3'b010, 0, 4'b0000, 0), "add");
    add_vec(1, 6'b000000, 6'b100101, 0, mk(c_rtype,      3'b000, 3'b001, 0, 4'b0000, 0), "or");
    add_vec(1, 6'b000000, 6'b100100, 0, mk(c_rtype,      3'b000, 3'b000, 0, 4'b0000, 0), "and");
    add_vec(1, 6'b000000, 6'b100010, 0, mk(c_rtype,      3'b000, 3'b110, 0, 4'b0000, 0), "sub");
    add_vec(1, 6'b000000, 6'b101010, 0, mk(c_rtype,      3'b000, 3'b111, 0, 4'b0000, 0), "slt");
    add_vec(1, 6'b000000, 6'b100110, 0, mk(c_rtype,      3'b000, 3'b100, 0, 4'b0000, 0), "xor");
    add_vec(1, 6'b000000, 6'b000101, 0, mk(c_rtype,      3'b000, 3'b101, 0, 4'b0000, 0), "xnor");
    add_vec(1, 6'b000000, 6'b010010, 0, mk(c_rtype,      3'b100, 3'b000, 0, 4'b0000, 0), "mflo_idle");
    add_vec(1, 6'b000000, 6'b010000, 0, mk(c_rtype,      3'b011, 3'b000, 0, 4'b0000, 0), "mfhi_idle");
    add_vec(1, 6'b100011, 6'b000000, 0, mk(9'b100010000, 3'b001, 3'b010, 0, 4'b0000, 0), "lw");
    add_vec(1, 6'b101011, 6'b000000, 0, mk(9'b010010000, 3'b000, 3'b010, 0, 4'b0000, 0), "sw");
    add_vec(1, 6'b000100, 6'b000000, 0, mk(9'b001000000, 3'b000, 3'b110, 0, 4'b0000, 0), "beq");
    add_vec(1, 6'b000101, 6'b000000, 0, mk(9'b001000000, 3'b000, 3'b110, 1, 4'b0000, 0), "bne");
    add_vec(1, 6'b001000, 6'b000000, 0, mk(9'b100010000, 3'b000, 3'b010, 0, 4'b0000, 0), "addi");
    add_vec(1, 6'b000010, 6'b000000, 0, mk(9'b100101000, 3'b010, 3'b000, 0, 4'b0000, 0), "jal");
    add_vec(1, 6'b001101, 6'b000000, 0, mk(9'b100010001, 3'b000, 3'b001, 0, 4'b0000, 0), "ori");
    add_vec(1, 6'b001100, 6'b000000, 0, mk(9'b100010001, 3'b000, 3'b000, 0, 4'b0000, 0), "andi");
    add_vec(1, 6'b001110, 6'b000000, 0, mk(9'b100010001, 3'b000, 3'b100, 0, 4'b0000, 0), "xori");
    add_vec(1, 6'b001010, 6'b000000, 0, mk(9'b100010000, 3'b000, 3'b111, 0, 4'b0000, 0), "slti");
    add_vec(1, 6'b001111, 6'b000000, 0, mk(9'b100010010, 3'b000, 3'b010, 0, 4'b0000, 0), "lui");
    add_vec(1, 6'b000000, 6'b111111, 0, mk(9'b000000000, 3'b000, 3'b000, 0, 4'b0000, 1), "ill_fn");
    add_vec(1, 6'b111111, 6'b000000, 0, mk(9'b000000000, 3'b000, 3'b000, 0, 4'b0000, 1), "ill_op");
    add_vec(0, 6'b000000, 6'b100000, 0, mk(9'b000000000, 3'b000, 3'b000, 0, 4'b0000, 0), "not_valid");
    add_vec(1, 6'b000000, 6'b100000, 1, mk(9'b000000000, 3'b000, 3'b000, 0, 4'b0000, 0), "flush_add");

    // Reset state
    reset = 1'b1;
    drive(0, 6'b0, 6'b0, 0, 0);
    step();
    step();
    check("reset_bundle", act0(), 0);
    check("reset_busy", if0.mdu_busy, 0);
    check("reset_stall", if0.mdu_stall, 0);
    reset = 1'b0;

    // Single-cycle decode table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].valid, tbl[i].op, tbl[i].fn, 0, tbl[i].flush);
      step();
      check(tbl[i].name, act0(), tbl[i].exp);
    end
    drive(0, 6'b0, 6'b0, 0, 0);
    step();

    // mult followed back-to-back by mflo
    drive(1, 6'b000000, 6'b011000, 0, 0);
    step();
    check("mult_issue", act0(), mk(c_rtype, 3'b000, 3'b000, 0, 4'b1100, 0));
    check("mult_busy", if0.mdu_busy, 1);
    drive(1, 6'b000000, 6'b010010, 0, 0);
    stall_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!if0.mdu_stall) break;
      stall_cnt++;
      step();
      check("mflo_stall_bubble", act0(), 0);
    end
    check("mflo_stall_cycles", stall_cnt, 4);
    step();
    check("mflo_issue", act0(), mk(c_rtype, 3'b100, 3'b000, 0, 4'b0000, 0));
    drive(0, 6'b0, 6'b0, 0, 0);
    step();

    // divu followed by addi; addi must issue without a stall
    drive(1, 6'b000000, 6'b011011, 0, 0);
    step();
    busy_cnt = 0;
    if (if0.mdu_busy) busy_cnt++;
    check("divu_issue", act0(), mk(c_rtype, 3'b000, 3'b000, 0, 4'b0010, 0));
    drive(1, 6'b001000, 6'b000000, 0, 0);
    #1;
    check("addi_no_stall", if0.mdu_stall, 0);
    step();
    if (if0.mdu_busy) busy_cnt++;
    check("addi_while_busy", act0(), mk(9'b100010000, 3'b000, 3'b010, 0, 4'b0000, 0));
    drive(0, 6'b0, 6'b0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      if (!if0.mdu_busy) break;
      step();
      if (if0.mdu_busy) busy_cnt++;
    end
    check("div_busy_cycles", busy_cnt, 32);

    // A flushed mult must not start the unit
    drive(1, 6'b000000, 6'b011000, 0, 1);
    step();
    check("flush_mult_bundle", act0(), 0);
    check("flush_mult_busy", if0.mdu_busy, 0);

    // An accepted mult held by stall_in keeps a single start pulse
    drive(1, 6'b000000, 6'b011000, 0, 0);
    step();
    ms_cnt = 0;
    if (if0.MultStart) ms_cnt++;
    check("stall_mult_first", if0.MultStart, 1);
    if0.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (if0.MultStart) ms_cnt++;
      check("stall_hold_sgn", if0.MultSgn, 1);
      check("stall_hold_rw", if0.Regwrite, 1);
    end
    check("stall_pulse_count", ms_cnt, 1);
    check("stall_busy_last", if0.mdu_busy, 1);
    drive(0, 6'b0, 6'b0, 0, 0);
    step();
    check("stall_expire", if0.mdu_busy, 0);
    check("stall_release_bubble", act0(), 0);

    // div aborted by reset in its 2nd busy cycle; dut1 must reject div
    drive(1, 6'b000000, 6'b011010, 0, 0);
    step();
    check("div_issue", act0(), mk(c_rtype, 3'b000, 3'b000, 0, 4'b0011, 0));
    check("nodiv_illegal", if1.illegal, 1);
    check("nodiv_start", if1.DivStart, 0);
    check("nodiv_busy", if1.mdu_busy, 0);
    drive(0, 6'b0, 6'b0, 0, 0);
    step();
    check("div_busy_2nd", if0.mdu_busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", if0.mdu_busy, 0);
    check("abort_bundle", act0(), 0);
    drive(1, 6'b000000, 6'b010000, 0, 0);
    #1;
    check("mfhi_after_abort_stall", if0.mdu_stall, 0);
    step();
    check("mfhi_after_abort", act0(), mk(c_rtype, 3'b011, 3'b000, 0, 4'b0000, 0));
    drive(0, 6'b0, 6'b0, 0, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_decode_ctrl.md
Name: pipelined_decode_ctrl

Overview:
Registered instruction-decode controller for the 5-stage MIPS pipeline. It decodes OP/FN into the ID/EX control bundle and adds a multi-cycle multiply/divide (MDU) issue tracker. The tracker raises a decode stall for MDU-dependent instructions while the unit is busy. Decode-time bubbles, flush and hold replace the combinational-only decode and its unknown outputs on illegal opcodes.

Parameters:
MULT_LAT, 4, cycles from MultStart until HI/LO are valid (>=1)
DIV_LAT, 32, cycles from DivStart until HI/LO are valid (>=1)
HAS_DIV, 1, 1 = decode div/divu; 0 = treat them as illegal
CNT_W, 6, busy-counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT)

Ports:
clk in 1 rising-edge clock
reset in 1 synchronous active-high reset
instr_valid in 1 OP/FN hold a real instruction
OP in 6 opcode
FN in 6 R-type function field
stall_in in 1 hazard unit holds the ID/EX register
flush in 1 load a bubble into the ID/EX register
Regwrite, Memwrite, Branch, Jump, ALUSrc out 1 each, registered controls
RegDst out 2 registered
ImmOp out 2 registered (00 sign-ext, 01 zero-ext, 10 lui)
WBSrc out 3 registered (000 ALU, 001 mem, 010 PC+4, 011 HI, 100 LO)
AluControl out 3 registered
brOp out 1 registered (0 beq, 1 bne)
MultStart, MultSgn, DivStart, DivSgn out 1 each, registered; start signals are one-cycle pulses
illegal out 1 registered; the decoded instruction was unsupported
mdu_busy out 1 state != IDLE
mdu_stall out 1 combinational; freeze IF/ID this cycle

Behaviour:
- Decode table, with bits {Regwrite,Memwrite,Branch,Jump,ALUSrc,RegDst,ImmOp}:
  - R-type (OP 000000): 1_0_0_0_0_01_00.
    - FN 100000 add → Alu 010
    - FN 100101 or → Alu 001
    - FN 100100 and → Alu 000
    - FN 100010 sub → Alu 110
    - FN 101010 slt → Alu 111
    - FN 100110 xor → Alu 100
    - FN 000101 xnor → Alu 101
    - FN 011000 mult → Mult 11
    - FN 011001 multu → Mult 10
    - FN 011010 div → Div 11
    - FN 011011 divu → Div 10
    - FN 010010 mflo → WB 100
    - FN 010000 mfhi → WB 011
  - lw 100011: 100010000, Alu 010, WB 001.
  - sw 101011: 010010000, Alu 010.
  - beq 000100: 001000000, Alu 110, brOp 0.
  - bne 000101: same as beq, brOp 1.
  - addi 001000: 100010000, Alu 010.
  - jal 000010: 100101000, WB 010.
  - ori 001101: 100010001, Alu 001.
  - andi 001100: 100010001, Alu 000.
  - xori 001110: 100010001, Alu 100.
  - slti 001010: 100010000, Alu 111.
  - lui 001111: 100010010, Alu 010.
- Bubble = every output 0. Every unlisted field value, including unknown FN, decodes to bubble with illegal=1. No X is ever produced.
- Register update priority, per clk:
  1. reset → bubble, FSM IDLE, counter 0.
  2. flush → bubble.
  3. stall_in → hold all registered outputs, except that start pulses are forced to 0 after the first cycle.
  4. mdu_stall or !instr_valid → bubble.
  5. Otherwise → load the decoded bundle (latency 1).
- accept = instr_valid & !flush & !stall_in & !mdu_stall.
- mdu_dep = decoded mult/multu/div/divu/mflo/mfhi.
- mdu_stall = instr_valid & mdu_busy & mdu_dep.
- FSM states IDLE, MULT, DIV:
  - IDLE→MULT on accepted mult/multu; counter ← MULT_LAT-1.
  - IDLE→DIV on accepted div/divu; counter ← DIV_LAT-1.
  - MULT/DIV: counter decrements every cycle, including during stall_in and flush. At counter==0 the state goes to IDLE next cycle.
  - The first MDU-dependent instruction accepted is the one presented in the cycle the FSM reads IDLE.
- Flushed or stalled MDU ops do not start the FSM. A flush does not abort an op already running.
- Non-MDU instructions issue freely while busy.
- Reset mid-operation aborts the op: IDLE, mdu_busy=0, no pending pulse.

Test Plan:
1. Reset, then add (000000/100000) → next cycle Regwrite=1, RegDst=01, AluControl=010, WBSrc=000, illegal=0.
2. mult, MULT_LAT=4, then mflo presented back-to-back → MultStart=1, MultSgn=1 for exactly 1 cycle; mdu_stall=1 for 4 cycles with bubbles; mflo issues WBSrc=100 in the 5th cycle after mult acceptance.
3. divu followed by addi → addi issues with no stall (ALUSrc=1, AluControl=010); mdu_busy=1 for DIV_LAT cycles; DivSgn=0.
4. OP=000000, FN=111111, and OP=111111 → outputs all 0, illegal=1. With HAS_DIV=0, div → illegal=1 and DivStart=0.
5. mult with flush=1 in the same cycle → no MultStart, mdu_busy stays 0. Then mult accepted and stall_in held for 3 cycles → MultStart high only in the first cycle; the counter still expires on time.
6. reset asserted in the 2nd busy cycle of div → next cycle mdu_busy=0, all outputs 0. A following mfhi issues immediately with WBSrc=011.
